// File: rtl/pc_stack_unit.sv
// Program counter and return-address stack sequencer for the PucCPU core.
// Registers the next pc from decoder flow-control strobes and keeps a LIFO of return addresses.
module pc_stack_unit #(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  STACK_DEPTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic                               jmp,
    input  logic                               cal,
    input  logic                               ret,
    input  logic                               push,
    input  logic                               pop,
    input  logic [PC_WIDTH-1:0]                jmp_addr,
    input  logic                               clr_err,
    output logic [PC_WIDTH-1:0]                pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               empty,
    output logic                               full,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = $clog2(STACK_DEPTH);
    localparam logic [DW-1:0] FULL_DEPTH = DW'(STACK_DEPTH);

    logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];
    logic [PC_WIDTH-1:0] r_pc;
    logic [DW-1:0]       r_depth;
    logic                r_overflow;
    logic                r_underflow;

    logic [PC_WIDTH-1:0] w_inc;
    logic [PC_WIDTH-1:0] w_top;
    logic [PC_WIDTH-1:0] w_nextPc;
    logic [DW-1:0]       w_nextDepth;
    logic [IW-1:0]       w_topIdx;
    logic [IW-1:0]       w_pushIdx;
    logic [IW-1:0]       w_wrIdx;
    logic                w_wrEn;
    logic                w_empty;
    logic                w_full;
    logic                w_ovfEvt;
    logic                w_unfEvt;

    assign w_empty   = (r_depth == '0);
    assign w_full    = (r_depth == FULL_DEPTH);
    assign w_inc     = r_pc + PC_WIDTH'(1);
    assign w_topIdx  = IW'(r_depth - DW'(1));
    assign w_pushIdx = IW'(r_depth);
    assign w_top     = r_stack[w_topIdx];

    always_comb begin
        w_nextPc    = w_inc;
        w_nextDepth = r_depth;
        w_wrEn      = 1'b0;
        w_wrIdx     = w_pushIdx;
        w_ovfEvt    = 1'b0;
        w_unfEvt    = ret && w_empty;

        if (ret && !w_empty) begin
            w_nextPc = w_top;
        end else if (jmp || cal) begin
            w_nextPc = jmp_addr;
        end

        // push+pop on a non-empty stack is a swap of the top entry
        case ({push, pop})
            2'b01: begin
                if (!w_empty) begin
                    w_nextDepth = r_depth - DW'(1);
                end else begin
                    w_unfEvt = 1'b1;
                end
            end
            2'b10: begin
                if (!w_full) begin
                    w_wrEn      = 1'b1;
                    w_nextDepth = r_depth + DW'(1);
                end else begin
                    w_ovfEvt = 1'b1;
                end
            end
            2'b11: begin
                w_wrEn = 1'b1;
                if (!w_empty) begin
                    w_wrIdx = w_topIdx;
                end else begin
                    w_unfEvt    = 1'b1;
                    w_nextDepth = r_depth + DW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_depth     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (en) begin
                r_pc    <= w_nextPc;
                r_depth <= w_nextDepth;
            end
            // a new error event beats a simultaneous clear
            if (en && w_ovfEvt) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (en && w_unfEvt) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // Stack storage carries no reset; entries above depth are never read.
    always_ff @(posedge clk) begin
        if (en && w_wrEn) begin
            r_stack[w_wrIdx] <= w_inc;
        end
    end

    assign pc        = r_pc;
    assign depth     = r_depth;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed self-checking bench for pc_stack_unit: fetch, calls/returns, overflow,
// underflow, swap/peek, hold, wrap and asynchronous reset.
module tb_pc_stack_unit;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       jmp, cal, ret, push, pop;
    logic [7:0] jmp_addr;
    logic       clr_err;
    logic [7:0] pc;
    logic [3:0] depth;
    logic       empty, full, overflow, underflow;

    int checks;
    int errors;

    // Return addresses expected from the eight nested calls, popped in LIFO order.
    logic [7:0] retExp [8] = '{8'hE1, 8'hD1, 8'hC1, 8'hB1, 8'hA1, 8'h91, 8'h81, 8'h12};

    pc_stack_unit #(.PC_WIDTH(8), .STACK_DEPTH(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .jmp(jmp), .cal(cal), .ret(ret), .push(push), .pop(pop),
        .jmp_addr(jmp_addr), .clr_err(clr_err),
        .pc(pc), .depth(depth), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of strobes, clock it in, and settle 1ns past the edge.
    task automatic applyStimulus(input logic j, input logic c, input logic r,
                                 input logic pu, input logic po, input logic [7:0] a);
        jmp = j; cal = c; ret = r; push = pu; pop = po; jmp_addr = a;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; clr_err = 1'b0;
        jmp = 0; cal = 0; ret = 0; push = 0; pop = 0; jmp_addr = 8'h00;
        #3;
        checks++; if (pc !== 8'h00) begin errors++; $display("[TB] FAIL reset_pc got %h exp 00", pc); end
        checks++; if (depth !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL reset_depth got %0d/%b/%b exp 0/1/0", depth, empty, full); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got %b%b exp 00", overflow, underflow); end
        @(posedge clk); #1;
        rst_n = 1'b1; en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 8'h00);
            checks++; if (pc !== 8'(i)) begin errors++; $display("[TB] FAIL seq_pc%0d got %h exp %h", i, pc, 8'(i)); end
        end
        checks++; if (depth !== 4'd0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL seq_depth got %0d/%b exp 0/1", depth, empty); end
    endtask

    task automatic test_call_return;
        applyStimulus(1, 0, 0, 0, 0, 8'h10);
        checks++; if (pc !== 8'h10) begin errors++; $display("[TB] FAIL jmp_pc got %h exp 10", pc); end
        applyStimulus(1, 1, 0, 1, 0, 8'h40);
        checks++; if (pc !== 8'h40 || depth !== 4'd1) begin errors++; $display("[TB] FAIL call_pc got %h/%0d exp 40/1", pc, depth); end
        applyStimulus(0, 0, 1, 0, 1, 8'h00);
        checks++; if (pc !== 8'h11 || depth !== 4'd0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL ret_pc got %h/%0d exp 11/0", pc, depth); end
    endtask

    task automatic test_nested_overflow;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1, 0, 1, 0, 8'(8'h80 + i * 16));
            checks++; if (depth !== 4'(i + 1)) begin errors++; $display("[TB] FAIL nest_depth%0d got %0d exp %0d", i, depth, i + 1); end
        end
        checks++; if (full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL nest_full got %b/%b exp 1/0", full, overflow); end
        applyStimulus(1, 1, 0, 1, 0, 8'h77);
        checks++; if (pc !== 8'h77 || depth !== 4'd8 || overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf got %h/%0d/%b exp 77/8/1", pc, depth, overflow); end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 1, 0, 1, 8'h00);
            checks++; if (pc !== retExp[i] || depth !== 4'(7 - i)) begin errors++; $display("[TB] FAIL lifo%0d got %h/%0d exp %h/%0d", i, pc, depth, retExp[i], 7 - i); end
        end
        checks++; if (empty !== 1'b1 || overflow !== 1'b1) begin errors++; $display("[TB] FAIL lifo_end got %b/%b exp 1/1", empty, overflow); end
        clr_err = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 8'h00);
        clr_err = 1'b0;
        checks++; if (overflow !== 1'b0 || pc !== 8'h13) begin errors++; $display("[TB] FAIL ovf_clr got %b/%h exp 0/13", overflow, pc); end
    endtask

    task automatic test_underflow;
        applyStimulus(1, 0, 0, 0, 0, 8'h05);
        applyStimulus(0, 0, 1, 0, 1, 8'h00);
        checks++; if (pc !== 8'h06 || underflow !== 1'b1 || depth !== 4'd0) begin errors++; $display("[TB] FAIL unf got %h/%b/%0d exp 06/1/0", pc, underflow, depth); end
        clr_err = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 8'h00);
        checks++; if (underflow !== 1'b0 || pc !== 8'h07) begin errors++; $display("[TB] FAIL unf_clr got %b/%h exp 0/07", underflow, pc); end
        clr_err = 1'b0;
        applyStimulus(0, 0, 0, 1, 1, 8'h00);
        checks++; if (pc !== 8'h08 || depth !== 4'd1 || underflow !== 1'b1) begin errors++; $display("[TB] FAIL pushpop_empty got %h/%0d/%b exp 08/1/1", pc, depth, underflow); end
        clr_err = 1'b1;
        applyStimulus(0, 0, 1, 0, 1, 8'h00);
        checks++; if (pc !== 8'h08 || depth !== 4'd0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL ret_clr got %h/%0d/%b exp 08/0/0", pc, depth, underflow); end
        applyStimulus(0, 0, 1, 0, 1, 8'h00);
        checks++; if (underflow !== 1'b1 || pc !== 8'h09) begin errors++; $display("[TB] FAIL set_wins got %b/%h exp 1/09", underflow, pc); end
        en = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 8'h00);
        checks++; if (underflow !== 1'b0 || pc !== 8'h09) begin errors++; $display("[TB] FAIL clr_noen got %b/%h exp 0/09", underflow, pc); end
        clr_err = 1'b0; en = 1'b1;
    endtask

    task automatic test_swap_peek;
        applyStimulus(1, 0, 0, 0, 0, 8'h1F);
        applyStimulus(0, 0, 0, 1, 0, 8'h00);
        applyStimulus(1, 0, 0, 0, 0, 8'h30);
        checks++; if (pc !== 8'h30 || depth !== 4'd1) begin errors++; $display("[TB] FAIL swap_setup got %h/%0d exp 30/1", pc, depth); end
        applyStimulus(0, 0, 1, 1, 1, 8'h00);
        checks++; if (pc !== 8'h20 || depth !== 4'd1) begin errors++; $display("[TB] FAIL swap got %h/%0d exp 20/1", pc, depth); end
        applyStimulus(0, 0, 1, 0, 0, 8'h00);
        checks++; if (pc !== 8'h31 || depth !== 4'd1) begin errors++; $display("[TB] FAIL peek got %h/%0d exp 31/1", pc, depth); end
        applyStimulus(0, 0, 1, 0, 1, 8'h00);
        checks++; if (pc !== 8'h31 || depth !== 4'd0) begin errors++; $display("[TB] FAIL peek_pop got %h/%0d exp 31/0", pc, depth); end
    endtask

    task automatic test_hold_wrap_reset;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 8'hAA);
            checks++; if (pc !== 8'h31 || depth !== 4'd0) begin errors++; $display("[TB] FAIL hold%0d got %h/%0d exp 31/0", i, pc, depth); end
        end
        en = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 8'hFF);
        applyStimulus(0, 0, 0, 0, 0, 8'h00);
        checks++; if (pc !== 8'h00) begin errors++; $display("[TB] FAIL wrap got %h exp 00", pc); end
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 8'h00);
        checks++; if (pc !== 8'h03 || depth !== 4'd3) begin errors++; $display("[TB] FAIL prereset got %h/%0d exp 03/3", pc, depth); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pc !== 8'h00 || depth !== 4'd0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL async_rst got %h/%0d exp 00/0", pc, depth); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_call_return();
        test_nested_overflow();
        test_underflow();
        test_swap_peek();
        test_hold_wrap_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Program-counter and return-address-stack sequencer for the PucCPU core. It sits between the instruction decoder and the instruction memory. Each cycle it consumes the decoder's flow-control strobes (`jmp`, `cal`, `ret`, `push`, `pop`) and `jmp_addr`, keeps a hardware LIFO of return addresses, and registers the next `pc`. It also reports stack depth and sticky overflow/underflow errors.

## Interface
- `PC_WIDTH`, 8: width of `pc`, `jmp_addr` and the stack entries.
- `STACK_DEPTH`, 8: number of return-address entries (≥2).
- `RESET_PC`, 0: value loaded into `pc` on reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  advance enable. When 0, all state holds and all strobes are ignored.
- `jmp`  in  1  redirect `pc` to `jmp_addr`.
- `cal`  in  1  redirect `pc` to `jmp_addr`; equivalent to `jmp` for the redirect decision.
- `ret`  in  1  redirect `pc` to the stack top.
- `push`  in  1  write `pc+1` onto the stack.
- `pop`  in  1  remove the stack top.
- `jmp_addr`  in  PC_WIDTH  jump/call target.
- `clr_err`  in  1  synchronous clear of `overflow`/`underflow`; works regardless of `en`.
- `pc`  out  PC_WIDTH  registered program counter.
- `depth`  out  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- `empty`  out  1  `depth==0`, combinational from `depth`.
- `full`  out  1  `depth==STACK_DEPTH`, combinational from `depth`.
- `overflow`  out  1  sticky: a push was attempted while full.
- `underflow`  out  1  sticky: a pop or ret was attempted while empty.

## Operation
- **Reset** (async, `rst_n=0`): `pc=RESET_PC`, `depth=0`, `overflow=0`, `underflow=0`. Stack RAM contents are don't-care and are not reset.
- `top` is the entry at index `depth-1`. It is valid only when `!empty`.
- `inc` is `pc+1` truncated to PC_WIDTH. From all-ones it wraps to 0.
- **Next-pc selection**, when `en=1`, in priority order:
  1. `ret && !empty` → `top`.
  2. `jmp || cal` → `jmp_addr`.
  3. otherwise → `inc`.
  - `ret` while empty does not redirect: `pc` follows rule 2 or 3 and `underflow` sets.
- **Stack update**, when `en=1`; `ret` reads `top` before this update is applied:
  - `pop` only, `!empty`: `depth-1`.
  - `pop` only, empty: no change; `underflow` sets.
  - `push` only, `!full`: write `inc` at index `depth`, then `depth+1`.
  - `push` only, full: no write, `depth` unchanged; `overflow` sets. The redirect still happens.
  - `push && pop`, `!empty`: overwrite `top` with `inc`; `depth` unchanged (swap).
  - `push && pop`, empty: `underflow` sets; the push proceeds normally (`depth` becomes 1).
- `ret` without `pop` is a peek-return: `pc` becomes `top` and the stack is unchanged.
- The decoder's encodings map as follows:
  - `CAL` = `jmp`+`cal`+`push`
  - `RET` = `ret`+`pop`
  - `JMP` = `jmp`
- **Error flags**:
  - Set and clear take effect on the same clock edge.
  - If `clr_err` coincides with a new error event, the flag reads 1 (set wins).
  - Flags clear only via `clr_err` or reset.

## Timing
- All outputs are registered except `empty` and `full`, which decode `depth`.
- Latency is 1 cycle: strobes sampled at edge N determine `pc`, `depth` and the flags after edge N.
- Strobes and `jmp_addr` must be stable in the cycle they are sampled. The decoder is combinational from the instruction fetched at the current `pc`.
- A redirect and its stack update complete on the same edge. A call immediately followed by a return restores `inc` of the call site with no bubble.
- `en=0` holds everything; `clr_err` is still honored.
- Reset assertion mid-operation forces the reset values immediately (asynchronous). Deassertion is expected to be synchronized upstream; the first update occurs on the first edge with `rst_n=1`.

## Test plan
- **Reset and sequential fetch:** assert `rst_n=0`, then release with `en=1` and no strobes for 5 cycles → `pc` reads 0,1,2,3,4,5; `depth=0`; `empty=1`.
- **Call then return:**
  - At `pc=0x10`, drive `jmp,cal,push` with `jmp_addr=0x40` → `pc=0x40`, `depth=1`, top=0x11.
  - Next cycle drive `ret,pop` → `pc=0x11`, `depth=0`.
- **Nested calls to full, then overflow:**
  - Perform 8 calls → `full=1`.
  - A 9th call with `jmp_addr=0x77` → `pc=0x77`, `depth=8`, `overflow=1`.
  - Perform 8 returns → addresses come back in LIFO order, ending with `empty=1`.
- **Underflow:** when empty, drive `ret,pop` at `pc=0x05` → `pc=0x06`, `underflow=1`, `depth=0`. Then `clr_err` → `underflow=0`.
- **Swap and peek:**
  - With `depth=1`, top=0x20, `pc=0x30`: drive `ret,push,pop` → `pc=0x20`, top=0x31, `depth=1`.
  - Then drive `ret` alone → `pc=0x31`, `depth=1`.
- **Hold, wrap and async reset:**
  - `en=0` with `jmp` asserted for 3 cycles → `pc` unchanged.
  - With `pc=0xFF` and no strobes → `pc=0x00`.
  - Assert `rst_n` low mid-cycle with `depth=3` → `pc=RESET_PC` and `depth=0` before the next edge.
